// File: rtl/dds_pwm_dac.sv
// Sign-magnitude sample to offset-binary PWM DAC with a one-deep
// sample buffer; duty changes only on period boundaries.
module dds_pwm_dac #(
  parameter int MAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sample_valid,
  input  logic             sign_in,
  input  logic [MAG_W-1:0] mag_in,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [MAG_W:0]   duty_q,
  output logic             busy
);

  localparam logic [MAG_W:0] MID = {1'b1, {MAG_W{1'b0}}};
  localparam logic [MAG_W:0] ONE = {{MAG_W{1'b0}}, 1'b1};
  localparam logic [MAG_W:0] TOP = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [MAG_W:0]   cnt_q;
  logic [MAG_W:0]   cnt_d;
  logic [MAG_W:0]   duty_d;
  logic [MAG_W:0]   pend_duty;
  logic             pend_valid;
  logic             pend_sign;
  logic [MAG_W-1:0] pend_mag;
  logic             boundary;
  logic             load;
  logic             active_d;
  logic             pwm_d;
  logic             ps_d;

  // Offset binary: mid-scale plus signed magnitude; -0 folds onto +0.
  always_comb begin
    pend_duty = MID + {1'b0, pend_mag};
    if (pend_sign)
      pend_duty = MID - {1'b0, pend_mag};
  end

  assign boundary = (state_q != IDLE) && (cnt_q == TOP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN, DRAIN: begin
        unique case (1'b1)
          boundary && en: begin
            state_d = RUN;
            cnt_d   = '0;
            load    = 1'b1;
          end
          boundary && !en: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
          default: begin
            cnt_d = cnt_q + ONE;
            if (!en)
              state_d = DRAIN;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    duty_d = duty_q;
    if (load && pend_valid)
      duty_d = pend_duty;
  end

  // Outputs are computed from next-cycle values so they register
  // in step with the counter they describe.
  assign active_d = (state_d != IDLE);
  assign pwm_d    = active_d && (cnt_d < duty_d);
  assign ps_d     = active_d && (cnt_d == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      duty_q       <= MID;
      pend_valid   <= 1'b0;
      pend_sign    <= 1'b0;
      pend_mag     <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      duty_q       <= duty_d;
      pwm_out      <= pwm_d;
      period_start <= ps_d;
      if (load && pend_valid) begin
        pend_valid <= 1'b0;
      end else if (sample_valid && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_sign  <= sign_in;
        pend_mag   <= mag_in;
      end
    end
  end

  assign sample_ready = !pend_valid;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dds_pwm_dac.sv
// Directed bench for dds_pwm_dac: conversion table plus
// handshake, drain and async-reset sequences.
module tb_dds_pwm_dac;

  logic       clk;
  logic       reset;
  logic       en;
  logic       sample_valid;
  logic       sign_in;
  logic [7:0] mag_in;
  logic       sample_ready;
  logic       pwm_out;
  logic       period_start;
  logic [8:0] duty_q;
  logic       busy;

  int checks;
  int errors;

  typedef struct {
    logic       sign;
    logic [7:0] mag;
    int         duty;
  } vec_t;

  vec_t vecs[6];

  dds_pwm_dac dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .sample_valid(sample_valid),
    .sign_in     (sign_in),
    .mag_in      (mag_in),
    .sample_ready(sample_ready),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .duty_q      (duty_q),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic s, input logic [7:0] m);
    sample_valid = 1'b1;
    sign_in      = s;
    mag_in       = m;
    step();
    sample_valid = 1'b0;
  endtask

  // Entered at cycle 0 of a period; leaves at cycle 0 of the next.
  task automatic run_period(input string name, input int exp);
    int hi;
    int bad;
    int rlow;
    hi   = 0;
    bad  = 0;
    rlow = 0;
    for (int i = 0; i < 512; i++) begin
      if (pwm_out === 1'b1) hi++;
      if (pwm_out !== logic'(i < exp)) bad++;
      if (period_start !== logic'(i == 0)) bad++;
      if (busy !== 1'b1) bad++;
      if (sample_ready !== 1'b1) rlow++;
      step();
    end
    chk({name, " high"}, hi, exp);
    chk({name, " shape"}, bad, 0);
    chk({name, " ready"}, rlow, 0);
  endtask

  initial begin
    int cnt_bad;

    checks = 0;
    errors = 0;
    vecs[0] = '{1'b1, 8'hFF, 1};
    vecs[1] = '{1'b1, 8'h00, 256};
    vecs[2] = '{1'b0, 8'h01, 257};
    vecs[3] = '{1'b1, 8'h80, 128};
    vecs[4] = '{1'b0, 8'h80, 384};
    vecs[5] = '{1'b1, 8'h01, 255};

    reset        = 1'b0;
    en           = 1'b0;
    sample_valid = 1'b0;
    sign_in      = 1'b0;
    mag_in       = 8'h00;
    @(negedge clk);
    chk("rst pwm", int'(pwm_out), 0);
    chk("rst ps", int'(period_start), 0);
    chk("rst duty", int'(duty_q), 256);
    chk("rst ready", int'(sample_ready), 1);
    chk("rst busy", int'(busy), 0);

    reset = 1'b1;
    repeat (3) step();
    chk("idle busy", int'(busy), 0);
    chk("idle ps", int'(period_start), 0);

    // Test 1: free run at mid-scale
    en = 1'b1;
    step();
    chk("t1 first ps", int'(period_start), 1);
    chk("t1 busy", int'(busy), 1);
    chk("t1 duty", int'(duty_q), 256);
    run_period("t1a", 256);
    run_period("t1b", 256);

    // Test 2: mid-period full-scale positive sample
    repeat (100) step();
    send(1'b0, 8'hFF);
    chk("t2 ready fall", int'(sample_ready), 0);
    repeat (410) step();
    chk("t2 ready at 511", int'(sample_ready), 0);
    chk("t2 no ps at 511", int'(period_start), 0);
    step();
    chk("t2 ps", int'(period_start), 1);
    chk("t2 duty", int'(duty_q), 511);
    chk("t2 ready rise", int'(sample_ready), 1);
    run_period("t2", 511);

    // Test 3: conversion table, including -0
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].sign, vecs[v].mag);
      chk($sformatf("v%0d ready", v), int'(sample_ready), 0);
      repeat (511) step();
      chk($sformatf("v%0d duty", v), int'(duty_q), vecs[v].duty);
      run_period($sformatf("v%0d", v), vecs[v].duty);
    end

    // Test 4: second sample held while buffer is full
    sample_valid = 1'b1;
    sign_in      = 1'b0;
    mag_in       = 8'h40;
    step();
    chk("t4 a ready", int'(sample_ready), 0);
    sign_in = 1'b1;
    repeat (510) step();
    chk("t4 b waits", int'(sample_ready), 0);
    step();
    chk("t4 a duty", int'(duty_q), 320);
    chk("t4 ready rise", int'(sample_ready), 1);
    step();
    chk("t4 b taken", int'(sample_ready), 0);
    sample_valid = 1'b0;
    repeat (511) step();
    chk("t4 b duty", int'(duty_q), 192);
    run_period("t4 b", 192);
    chk("t4 no dup", int'(duty_q), 192);

    // Test 5: drain to idle, then re-raise during drain
    repeat (100) step();
    en = 1'b0;
    step();
    cnt_bad = 0;
    for (int c = 101; c < 512; c++) begin
      if (pwm_out !== logic'(c < 192)) cnt_bad++;
      if (busy !== 1'b1) cnt_bad++;
      step();
    end
    chk("t5 drain", cnt_bad, 0);
    cnt_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (pwm_out !== 1'b0) cnt_bad++;
      if (period_start !== 1'b0) cnt_bad++;
      if (busy !== 1'b0) cnt_bad++;
      step();
    end
    chk("t5 idle", cnt_bad, 0);
    en = 1'b1;
    step();
    chk("t5 restart ps", int'(period_start), 1);
    repeat (100) step();
    en = 1'b0;
    step();
    repeat (50) step();
    en = 1'b1;
    cnt_bad = 0;
    for (int c = 151; c < 511; c++) begin
      if (busy !== 1'b1) cnt_bad++;
      step();
    end
    chk("t5 busy", cnt_bad, 0);
    step();
    chk("t5 no gap ps", int'(period_start), 1);
    run_period("t5 resume", 192);

    // Test 6: async reset mid-period with a pending sample
    send(1'b0, 8'h10);
    repeat (299) step();
    chk("t6 pend", int'(sample_ready), 0);
    chk("t6 busy", int'(busy), 1);
    #1 reset = 1'b0;
    #1;
    chk("t6 async pwm", int'(pwm_out), 0);
    chk("t6 async ps", int'(period_start), 0);
    chk("t6 async busy", int'(busy), 0);
    chk("t6 async ready", int'(sample_ready), 1);
    chk("t6 async duty", int'(duty_q), 256);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    step();
    chk("t6 ps", int'(period_start), 1);
    chk("t6 duty", int'(duty_q), 256);
    run_period("t6", 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_pwm_dac.md
Name: dds_pwm_dac

Overview:
Output stage directly downstream of the DDS top. It consumes the 9-bit sign-magnitude sine sample (sign bit plus 8-bit magnitude) and converts it to offset-binary duty. It then drives a single-bit PWM output suitable for an RC reconstruction filter. A one-deep sample buffer with a valid/ready handshake decouples the DDS sample rate from the PWM period. Duty updates occur only on period boundaries, so no glitches occur inside a period.

Parameters:
MAG_W, 8, magnitude width of the incoming sample. The PWM period is 2^(MAG_W+1) clocks, which is 512 at the default.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset.
en  input  1  run request; level-sensitive.
sample_valid  input  1  source presents a sample this cycle.
sign_in  input  1  sample sign, 1 = negative (the DDS msb).
mag_in  input  MAG_W  sample magnitude.
sample_ready  output  1  buffer can accept a sample; equals !pend_valid.
pwm_out  output  1  registered PWM output.
period_start  output  1  registered one-cycle pulse at cycle 0 of each running period.
duty_q  output  MAG_W+1  duty currently applied, for observation.
busy  output  1  high in RUN or DRAIN.

Behaviour:
Reset (reset=0, asynchronous):
- state=IDLE, cnt=0, duty_q=2^MAG_W (256), pend_valid=0, pend data=0.
- pwm_out=0, period_start=0, busy=0.
- sample_ready=1.

Handshake:
- A transfer occurs when sample_valid && sample_ready at a clock edge. sign/mag are captured into the pending register and pend_valid is set.
- sample_ready = !pend_valid, combinational from a register. No combinational path from sample_valid.
- A source holding valid while ready=0 is not captured. The source must hold its data.

Conversion:
- duty = sign ? 256 - mag : 256 + mag, computed in MAG_W+1 bits. The constant 256 generalises to 2^MAG_W.
- Range is 1..511. Negative zero (sign=1, mag=0) maps to 256, the same as +0.
- duty 0 and duty 512 are unreachable, so pwm_out toggles at least once every period.

Counter:
- cnt is MAG_W+1 bits and increments by 1 each clock in RUN/DRAIN.
- It wraps from 511 to 0. The boundary is the cycle with cnt==511.

Duty load:
- At each boundary, and on IDLE->RUN entry, if pend_valid then duty_q <= converted pend and pend_valid <= 0. Otherwise duty_q holds its previous value.
- Load and capture in the same cycle cannot collide, because ready=0 whenever pend_valid=1.
- sample_ready rises the cycle after a boundary load.

Output timing:
- pwm_out <= (next cnt < next duty) and period_start <= (next cnt == 0), both registered. As a result, period_start and the first high cycle of pwm_out coincide.
- pwm_out is high for exactly duty_q consecutive cycles starting at the period_start cycle, then low for 512 - duty_q cycles.

FSM:
- IDLE: cnt=0, pwm_out=0, period_start=0, busy=0. On en=1, perform the entry load and go to RUN. The first period_start appears 1 clock after en is sampled high.
- RUN: counts and produces PWM output. If en=0 is sampled, go to DRAIN (the current period continues).
- DRAIN: the current period runs to completion with no further loads.
  - At the boundary: if en=1, go to RUN with a normal boundary load. If en=0, go to IDLE with cnt=0 and pwm_out=0 on the next cycle, and no period_start.
  - If en returns to 1 during DRAIN, the state returns to RUN at the boundary. The period is never truncated.
- The buffer accepts samples in every state, including IDLE.

Reset asserted mid-period:
- All outputs go to their reset values immediately, without waiting for a clock edge.
- Any pending sample is discarded.
- After release, the block stays in IDLE until en is sampled high.

Test Plan:
1. Release reset, en=1, no samples -> duty_q=256; pwm_out alternates 256 high / 256 low; period_start every 512 clocks; sample_ready=1 throughout.
2. Mid-period send sign=0, mag=0xFF -> ready falls next cycle; next period duty_q=511, pwm 511 high / 1 low; ready returns high the cycle after the boundary.
3. Send sign=1, mag=0xFF, then sign=1, mag=0x00 -> one period with 1 high / 511 low, then a period with duty 256 (negative zero equals +0).
4. Present two samples in one period, holding the second valid -> the first is accepted; the second waits with ready=0 and is accepted the cycle after the boundary; it is applied one period later; no sample is lost or duplicated.
5. Drop en at cnt=100 -> busy stays high through cnt=511, the full duty is completed, then IDLE: pwm_out=0, no period_start, busy=0. Re-raise en during DRAIN in a second run -> continuous periods with no gap.
6. Assert reset at cnt=300 with pend_valid=1 -> outputs zero asynchronously, duty_q=256, ready=1. After release with en=1, the first period uses duty 256.
